// File: rtl/priority_rr_arbiter.sv
// Lock-until-release round-robin arbiter with a registered one-hot grant.
// Define PRIORITY_RR_ARBITER_TIMEOUT_EN to bound grant tenure to MAX_HOLD cycles under contention.
module priority_rr_arbiter #(
  parameter int unsigned REQ_WIDTH = 8,
  parameter int unsigned MAX_HOLD  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_WIDTH-1:0]         req,
  output logic [REQ_WIDTH-1:0]         gnt,
  output logic                         gnt_valid,
  output logic [$clog2(REQ_WIDTH)-1:0] gnt_id
);

  localparam int unsigned IDW = $clog2(REQ_WIDTH);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e               state_q;
  logic [IDW-1:0]       ptr_q;
  logic [REQ_WIDTH-1:0] gnt_q;
  logic                 valid_q;
  logic [IDW-1:0]       gnt_id_q;

  logic                 release_c;
  logic [IDW-1:0]       ptr_d;
  logic [IDW-1:0]       start_c;
  logic                 pick_valid_c;
  logic [IDW-1:0]       pick_id_c;

`ifdef PRIORITY_RR_ARBITER_TIMEOUT_EN
  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [HW-1:0] hold_q;
  logic          timeout_c;

  // Forced release only when someone else is waiting; a lone owner keeps the grant.
  assign timeout_c = (hold_q == HOLD_LAST) && ((req & ~gnt_q) != '0);
`else
  logic timeout_c;

  assign timeout_c = 1'b0;
`endif

  assign release_c = (state_q == GRANT) && (!req[gnt_id_q] || timeout_c);
  assign ptr_d     = (32'(gnt_id_q) == REQ_WIDTH - 1) ? '0 : gnt_id_q + 1'b1;
  assign start_c   = (state_q == GRANT) ? ptr_d : ptr_q;

  // First set request bit scanning circularly upward from start_c.
  always_comb begin
    int unsigned pos;
    pick_valid_c = 1'b0;
    pick_id_c    = '0;
    pos          = 0;
    for (int unsigned k = 0; k < REQ_WIDTH; k++) begin
      pos = (32'(start_c) + k) % REQ_WIDTH;
      if (!pick_valid_c && req[pos]) begin
        pick_valid_c = 1'b1;
        pick_id_c    = IDW'(pos);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      gnt_id_q <= '0;
`ifdef PRIORITY_RR_ARBITER_TIMEOUT_EN
      hold_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid_c) begin
            state_q  <= GRANT;
            gnt_q    <= REQ_WIDTH'(1) << pick_id_c;
            valid_q  <= 1'b1;
            gnt_id_q <= pick_id_c;
`ifdef PRIORITY_RR_ARBITER_TIMEOUT_EN
            hold_q   <= '0;
`endif
          end
        end
        GRANT: begin
          if (release_c) begin
            ptr_q <= ptr_d;
`ifdef PRIORITY_RR_ARBITER_TIMEOUT_EN
            hold_q <= '0;
`endif
            if (pick_valid_c) begin
              gnt_q    <= REQ_WIDTH'(1) << pick_id_c;
              valid_q  <= 1'b1;
              gnt_id_q <= pick_id_c;
            end else begin
              state_q  <= IDLE;
              gnt_q    <= '0;
              valid_q  <= 1'b0;
              gnt_id_q <= '0;
            end
          end else begin
`ifdef PRIORITY_RR_ARBITER_TIMEOUT_EN
            if (hold_q != HOLD_LAST) hold_q <= hold_q + 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_priority_rr_arbiter.sv
// Directed and randomized checks of priority_rr_arbiter against a behavioural owner/pointer model.
module tb_priority_rr_arbiter;

  localparam int unsigned W  = 8;
  localparam int unsigned MH = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] req;
  logic [W-1:0] gnt;
  logic         gnt_valid;
  logic [2:0]   gnt_id;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state: owner index (-1 = none), search pointer, tenure.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_ten   = 0;

  priority_rr_arbiter #(.REQ_WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_from(input logic [W-1:0] r, input int start);
    for (int k = 0; k < int'(W); k++) begin
      int idx;
      idx = (start + k) % int'(W);
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [W-1:0] r, input logic rs);
    bit rel;
    if (rs) begin
      m_owner = -1; m_ptr = 0; m_ten = 0;
    end else if (m_owner < 0) begin
      m_owner = first_from(r, m_ptr);
      m_ten   = 0;
    end else begin
      rel = !r[m_owner];
`ifdef PRIORITY_RR_ARBITER_TIMEOUT_EN
      if (m_ten == int'(MH) - 1 && (r & ~(W'(1) << m_owner)) != '0) rel = 1'b1;
`endif
      if (rel) begin
        m_ptr   = (m_owner + 1) % int'(W);
        m_owner = first_from(r, m_ptr);
        m_ten   = 0;
      end else if (m_ten < int'(MH) - 1) begin
        m_ten = m_ten + 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic [W-1:0] r, input logic rs);
    logic [W-1:0] eg;
    req = r;
    rst = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
    eg = (m_owner < 0) ? '0 : (W'(1) << m_owner);
    check("model_gnt", 32'(gnt), 32'(eg));
    check("model_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    check("model_id", 32'(gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check("onehot", 32'($countones(gnt) <= 1), 32'd1);
  endtask

  initial begin
    logic [W-1:0] seq [0:8];
    logic [W-1:0] r;
    req = '0;
    rst = 1'b1;

    // Reset state
    step('0, 1'b1);
    step('0, 1'b1);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_valid", 32'(gnt_valid), 32'h0);
    check("rst_id", 32'(gnt_id), 32'h0);

    // Back-to-back handover without an idle cycle
    step(8'h05, 1'b0);
    check("b2b_first_gnt", 32'(gnt), 32'h01);
    check("b2b_first_id", 32'(gnt_id), 32'd0);
    step(8'h04, 1'b0);
    check("b2b_second_gnt", 32'(gnt), 32'h04);
    check("b2b_second_id", 32'(gnt_id), 32'd2);

    // Full rotation with wrap, each owner dropping for one cycle
    step('0, 1'b1);
    seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    step(8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("rot_hold", 32'(gnt), 32'(seq[i]));
      step(8'hFF, 1'b0);
      check("rot_hold2", 32'(gnt), 32'(seq[i]));
      step(8'hFF & ~seq[i], 1'b0);
      check("rot_next", 32'(gnt), 32'(seq[i+1]));
    end

    // Tenure under contention
    step('0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      step(8'h03, 1'b0);
`ifdef PRIORITY_RR_ARBITER_TIMEOUT_EN
      check("tenure", 32'(gnt), ((k / 4) % 2 == 1) ? 32'h02 : 32'h01);
`else
      check("tenure", 32'(gnt), 32'h01);
`endif
    end

    // Reset overrides an active grant
    step('0, 1'b1);
    step(8'h10, 1'b0);
    check("pre_rst_gnt", 32'(gnt), 32'h10);
    step(8'h90, 1'b1);
    check("rst_edge_gnt", 32'(gnt), 32'h0);
    step(8'h90, 1'b0);
    check("post_rst_gnt", 32'(gnt), 32'h10);

    // Idle with no requests, then top requester
    step('0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step('0, 1'b0);
      check("idle_gnt", 32'(gnt), 32'h0);
      check("idle_valid", 32'(gnt_valid), 32'h0);
      check("idle_id", 32'(gnt_id), 32'h0);
    end
    step(8'h80, 1'b0);
    check("top_gnt", 32'(gnt), 32'h80);
    check("top_id", 32'(gnt_id), 32'd7);

    // Randomized traffic: requests mostly persist, occasionally change or reset
    r = '0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) r = W'($urandom);
      if ($urandom_range(0, 5) == 0 && gnt_valid) r[gnt_id] = 1'b0;
      if ($urandom_range(0, 7) == 0) r = '0;
      step(r, $urandom_range(0, 49) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
